// File: rtl/mem_access.sv
// mem_access: memory pipeline stage between execute and data memory.
//   Accepts an execute-stage result, runs a req/ack bus transaction for
//   loads and stores (stalling upstream while it is outstanding), and
//   returns the aligned, extended load data or the pass-through ALU result.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid, is_load,        instruction from execute and its memory type
//   is_store, funct3
//   alu_result, store_data    effective address / result, store operand
//   rd_wren_in                destination write enable from execute
//   stall                     hold upstream pipeline (combinational)
//   out_valid, result,        registered writeback / forward outputs
//   rd_wren_out, fault
//   bus_req, bus_we,          registered data-memory request
//   bus_addr, bus_be,
//   bus_wdata
//   bus_ack, bus_rdata        memory acknowledge and read word
module mem_access #(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic            rd_wren_in,
  output logic            stall,
  output logic            out_valid,
  output logic [XLEN-1:0] result,
  output logic            rd_wren_out,
  output logic            fault,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ack,
  input  logic [XLEN-1:0] bus_rdata
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int CW = 16;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(ACK_TIMEOUT - 1);

  logic [1:0]      state_r;
  logic [CW-1:0]   cnt_r;
  logic [XLEN-1:0] addr_r;
  logic [2:0]      funct3_r;
  logic            rd_wren_r;
  logic            is_store_r;

  logic is_mem_s;
  logic illegal_s;
  logic stall_s;
  logic timeout_s;

  // Illegal encodings, bad store widths and misaligned halfword/word accesses.
  function automatic logic access_illegal(input logic ld, input logic st,
                                          input logic [2:0] f3, input logic [1:0] a);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = a[0];
      3'b010:  bad = (a != 2'b00);
      3'b100:  bad = st;
      3'b101:  bad = st | a[0];
      default: bad = 1'b1;
    endcase
    return bad | (ld & st);
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate the store operand across every lane it could occupy.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[8*a +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign is_mem_s  = is_load | is_store;
  assign illegal_s = access_illegal(is_load, is_store, funct3, alu_result[1:0]);
  assign timeout_s = (ACK_TIMEOUT != 0) && (cnt_r == TIMEOUT_LAST);

  // Stall while a legal memory op is being accepted or the bus is outstanding.
  always_comb begin
    stall_s = 1'b0;
    if (state_r == ST_REQ) begin
      stall_s = 1'b1;
    end else if ((state_r == ST_IDLE) && in_valid && is_mem_s && !illegal_s) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  assign stall = stall_s;

  // FSM, bus request registers and registered writeback outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      addr_r      <= '0;
      funct3_r    <= 3'd0;
      rd_wren_r   <= 1'b0;
      is_store_r  <= 1'b0;
      out_valid   <= 1'b0;
      result      <= '0;
      rd_wren_out <= 1'b0;
      fault       <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_be      <= 4'd0;
      bus_wdata   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          out_valid <= 1'b0;
          fault     <= 1'b0;
          if (in_valid) begin
            if (!is_mem_s) begin
              out_valid   <= 1'b1;
              result      <= alu_result;
              rd_wren_out <= rd_wren_in;
            end else if (illegal_s) begin
              out_valid   <= 1'b1;
              fault       <= 1'b1;
              rd_wren_out <= 1'b0;
              result      <= alu_result;
            end else begin
              state_r    <= ST_REQ;
              cnt_r      <= '0;
              addr_r     <= alu_result;
              funct3_r   <= funct3;
              rd_wren_r  <= rd_wren_in;
              is_store_r <= is_store;
              bus_req    <= 1'b1;
              bus_we     <= is_store;
              bus_addr   <= {alu_result[XLEN-1:2], 2'b00};
              // Loads always fetch the full word; lane selection happens on return.
              bus_be     <= is_store ? store_be(funct3, alu_result[1:0]) : 4'b1111;
              bus_wdata  <= is_store ? store_lanes(funct3, store_data) : '0;
            end
          end
        end
        ST_REQ: begin
          if (bus_ack || timeout_s) begin
            state_r   <= ST_RESP;
            out_valid <= 1'b1;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'd0;
            bus_wdata <= '0;
            // An ack arriving on the final allowed cycle still completes normally.
            if (bus_ack) begin
              fault <= 1'b0;
              if (is_store_r) begin
                result      <= addr_r;
                rd_wren_out <= 1'b0;
              end else begin
                result      <= load_extract(funct3_r, addr_r[1:0], bus_rdata);
                rd_wren_out <= rd_wren_r;
              end
            end else begin
              fault       <= 1'b1;
              rd_wren_out <= 1'b0;
              result      <= addr_r;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_RESP: begin
          out_valid <= 1'b0;
          fault     <= 1'b0;
          state_r   <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          out_valid <= 1'b0;
          bus_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed self-checking bench for mem_access with a
// scoreboard of expected writeback results (ACK_TIMEOUT set to 4).
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, is_load, is_store, rd_wren_in;
  logic [2:0]  funct3;
  logic [31:0] alu_result, store_data;
  logic        stall, out_valid, rd_wren_out, fault;
  logic [31:0] result;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  typedef struct packed {
    logic [31:0] res;
    logic        wr;
    logic        flt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mem_access #(.XLEN(32), .ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .is_load(is_load),
    .is_store(is_store), .funct3(funct3), .alu_result(alu_result),
    .store_data(store_data), .rd_wren_in(rd_wren_in), .stall(stall),
    .out_valid(out_valid), .result(result), .rd_wren_out(rd_wren_out),
    .fault(fault), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then compare any produced output against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_result", result, e.res);
        chk("sb_rd_wren", 32'(rd_wren_out), 32'(e.wr));
        chk("sb_fault", 32'(fault), 32'(e.flt));
      end
    end
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic wr);
    in_valid   = 1'b1;
    is_load    = ld;
    is_store   = st;
    funct3     = f3;
    alu_result = a;
    store_data = d;
    rd_wren_in = wr;
    #1;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bus_ack = 1'b0; bus_rdata = 32'd0;
    in_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    alu_result = 32'd0; store_data = 32'd0; rd_wren_in = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_bus_be", 32'(bus_be), 32'd0);
    chk("rst_bus_wdata", bus_wdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);

    // Non-memory op: one-cycle latency, no stall
    drive(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'd0, 1'b1);
    chk("nonmem_stall", 32'(stall), 32'd0);
    sb.push_back('{res: 32'h0000_1234, wr: 1'b1, flt: 1'b0});
    tick();
    idle_in();
    chk("nonmem_drained", sb.size(), 32'd0);

    // LB at 0x1003 with same-cycle ack
    drive(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0, 1'b1);
    chk("lb_accept_stall", 32'(stall), 32'd1);
    sb.push_back('{res: 32'hFFFF_FF80, wr: 1'b1, flt: 1'b0});
    tick();
    idle_in();
    bus_ack = 1'b1; bus_rdata = 32'h80FF_FF00;
    #1;
    chk("lb_bus_req", 32'(bus_req), 32'd1);
    chk("lb_bus_addr", bus_addr, 32'h0000_1000);
    chk("lb_bus_be", 32'(bus_be), 32'hF);
    chk("lb_bus_we", 32'(bus_we), 32'd0);
    chk("lb_req_stall", 32'(stall), 32'd1);
    tick();
    bus_ack = 1'b0;
    chk("lb_drained", sb.size(), 32'd0);
    chk("lb_resp_stall", 32'(stall), 32'd0);
    tick();

    // LBU from the same word
    drive(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'd0, 1'b1);
    sb.push_back('{res: 32'h0000_0080, wr: 1'b1, flt: 1'b0});
    tick();
    idle_in();
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick();
    chk("lbu_drained", sb.size(), 32'd0);

    // SH at 0x2002, ack on the 4th REQ cycle (last before timeout)
    drive(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 1'b1);
    sb.push_back('{res: 32'h0000_2002, wr: 1'b0, flt: 1'b0});
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      bus_ack = (i == 3);
      #1;
      chk("sh_bus_req", 32'(bus_req), 32'd1);
      chk("sh_bus_be", 32'(bus_be), 32'hC);
      chk("sh_bus_wdata", bus_wdata, 32'hBEEF_BEEF);
      chk("sh_bus_we", 32'(bus_we), 32'd1);
      chk("sh_bus_addr", bus_addr, 32'h0000_2000);
      chk("sh_stall", 32'(stall), 32'd1);
      tick();
    end
    bus_ack = 1'b0;
    chk("sh_drained", sb.size(), 32'd0);
    tick();
    tick();

    // SB at 0x0010_0001
    drive(1'b0, 1'b1, 3'b000, 32'h0010_0001, 32'h1234_5678, 1'b1);
    sb.push_back('{res: 32'h0010_0001, wr: 1'b0, flt: 1'b0});
    tick();
    idle_in();
    bus_ack = 1'b1;
    #1;
    chk("sb_bus_be", 32'(bus_be), 32'h2);
    chk("sb_bus_wdata", bus_wdata, 32'h7878_7878);
    tick();
    bus_ack = 1'b0;
    tick();
    chk("sb_drained", sb.size(), 32'd0);

    // Misaligned LW: immediate fault, no bus request
    drive(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'd0, 1'b1);
    chk("lw_mis_stall", 32'(stall), 32'd0);
    sb.push_back('{res: 32'h0000_3001, wr: 1'b0, flt: 1'b1});
    tick();
    idle_in();
    chk("lw_mis_bus_req", 32'(bus_req), 32'd0);
    chk("lw_mis_drained", sb.size(), 32'd0);

    // Store with an unsigned width encoding is illegal
    drive(1'b0, 1'b1, 3'b100, 32'h0000_3004, 32'd0, 1'b1);
    sb.push_back('{res: 32'h0000_3004, wr: 1'b0, flt: 1'b1});
    tick();
    // Both load and store set is illegal
    drive(1'b1, 1'b1, 3'b010, 32'h0000_3008, 32'd0, 1'b1);
    sb.push_back('{res: 32'h0000_3008, wr: 1'b0, flt: 1'b1});
    tick();
    idle_in();
    chk("illegal_bus_req", 32'(bus_req), 32'd0);
    tick();
    chk("illegal_drained", sb.size(), 32'd0);

    // Timeout: load with no ack, four REQ cycles then faulted response
    drive(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'd0, 1'b1);
    sb.push_back('{res: 32'h0000_4000, wr: 1'b0, flt: 1'b1});
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      chk("to_bus_req", 32'(bus_req), 32'd1);
      tick();
    end
    chk("to_drained", sb.size(), 32'd0);
    chk("to_bus_req_done", 32'(bus_req), 32'd0);
    tick();
    chk("to_idle_stall", 32'(stall), 32'd0);

    // Reset in the 2nd REQ cycle abandons the access
    drive(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'd0, 1'b1);
    tick();
    idle_in();
    tick();
    chk("rstreq_bus_req_before", 32'(bus_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rstreq_bus_req", 32'(bus_req), 32'd0);
    chk("rstreq_out_valid", 32'(out_valid), 32'd0);
    chk("rstreq_bus_addr", bus_addr, 32'd0);
    chk("rstreq_stall", 32'(stall), 32'd0);
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    bus_ack = 1'b0;
    tick();
    chk("rstreq_result", result, 32'd0);
    chk("final_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
